// File: rtl/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Lets NumPorts word-level requesters share one single-port SRAM model. Each
// cycle the round-robin arbiter grants at most one request and drives the
// SRAM port with it. The SRAM returns read data one cycle later, and this
// block routes that data back to the requester that was granted. An access
// beyond the SRAM depth still uses its grant slot, but the SRAM is not
// touched and the response is flagged as an error.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   req_i        per-port request
//   we_i         per-port write enable
//   addr_i       per-port byte address, port p at [p*AddrWidth +: AddrWidth]
//   be_i         per-port byte enables
//   wdata_i      per-port write data
//   gnt_o        one-hot grant, same cycle as the accepted request
//   rvalid_o     one-hot response valid, one cycle after the grant
//   rdata_o      response read data, shared by all ports
//   err_o        out-of-range flag, qualified by rvalid_o
//   mem_req_o    SRAM request
//   mem_we_o     SRAM write enable
//   mem_addr_o   SRAM word index
//   mem_be_o     SRAM byte enables
//   mem_wdata_o  SRAM write data
//   mem_rdata_i  SRAM read data, valid one cycle after mem_req_o
// ---------------------------------------------------------------------------
module tb_mem_arbiter #(
    parameter int NumPorts  = 2,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int NumWords  = 2**25
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               req_i,
    input  logic [NumPorts-1:0]               we_i,
    input  logic [NumPorts*AddrWidth-1:0]     addr_i,
    input  logic [NumPorts*DataWidth/8-1:0]   be_i,
    input  logic [NumPorts*DataWidth-1:0]     wdata_i,
    output logic [NumPorts-1:0]               gnt_o,
    output logic [NumPorts-1:0]               rvalid_o,
    output logic [DataWidth-1:0]              rdata_o,
    output logic                              err_o,
    output logic                              mem_req_o,
    output logic                              mem_we_o,
    output logic [$clog2(NumWords)-1:0]       mem_addr_o,
    output logic [DataWidth/8-1:0]            mem_be_o,
    output logic [DataWidth-1:0]              mem_wdata_o,
    input  logic [DataWidth-1:0]              mem_rdata_i
);

    localparam int BeWidth    = DataWidth / 8;
    localparam int OffW       = $clog2(BeWidth);
    localparam int WordW      = $clog2(NumWords);
    localparam int IdxW       = $clog2(NumPorts);
    // Any byte-address bit at or above this position means "beyond the SRAM".
    localparam int RangeShift = WordW + OffW;

    // Unpacked per-port views of the flattened request buses.
    logic [AddrWidth-1:0] addr_arr  [NumPorts];
    logic [BeWidth-1:0]   be_arr    [NumPorts];
    logic [DataWidth-1:0] wdata_arr [NumPorts];
    logic [NumPorts-1:0]  in_range;

    always_comb begin
        in_range = '0;
        for (int p = 0; p < NumPorts; p++) begin
            addr_arr[p]  = addr_i[p*AddrWidth +: AddrWidth];
            be_arr[p]    = be_i[p*BeWidth +: BeWidth];
            wdata_arr[p] = wdata_i[p*DataWidth +: DataWidth];
            in_range[p]  = ((addr_arr[p] >> RangeShift) == '0);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    logic [IdxW-1:0]     last_q, last_d;
    logic [IdxW-1:0]     win_idx, cand;
    logic                win_valid;
    logic                win_in_range;
    logic [NumPorts-1:0] gnt;

    // Scan starts one past the last winner, so the port that was just
    // served has the lowest priority on the next cycle.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = last_q;
        cand      = '0;
        for (int k = 1; k <= NumPorts; k++) begin
            cand = IdxW'((int'(last_q) + k) % NumPorts);
            if (!win_valid && req_i[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (win_valid) begin
            gnt[win_idx] = 1'b1;
        end
    end

    assign win_in_range = in_range[win_idx];
    assign last_d       = win_valid ? win_idx : last_q;
    assign gnt_o        = gnt;

    // ------------------------------------------------------------------
    // SRAM port: driven only for an in-range winner. Everything else
    // (idle or out of range) leaves the port quiet and zeroed.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (win_valid && win_in_range) begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_i[win_idx];
            mem_addr_o  = WordW'(addr_arr[win_idx] >> OffW);
            mem_be_o    = be_arr[win_idx];
            mem_wdata_o = wdata_arr[win_idx];
        end
    end

    // ------------------------------------------------------------------
    // Response tracking: remembers who was granted and what kind of
    // access it was, so next cycle's SRAM data can be routed or masked.
    // ------------------------------------------------------------------
    logic [NumPorts-1:0] rsp_port_q, rsp_port_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_we_q, rsp_we_d;

    assign rsp_port_d = gnt;
    assign rsp_err_d  = win_valid & ~win_in_range;
    assign rsp_we_d   = win_valid & we_i[win_idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q     <= IdxW'(NumPorts - 1);
            rsp_port_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_we_q   <= 1'b0;
        end else begin
            last_q     <= last_d;
            rsp_port_q <= rsp_port_d;
            rsp_err_q  <= rsp_err_d;
            rsp_we_q   <= rsp_we_d;
        end
    end

    assign rvalid_o = rsp_port_q;
    assign err_o    = (|rsp_port_q) & rsp_err_q;
    // Only an in-range read carries SRAM data; writes and errors return 0
    // because the SRAM output holds stale data on those cycles.
    assign rdata_o  = ((|rsp_port_q) && !rsp_err_q && !rsp_we_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_tb_mem_arbiter.sv
module tb_tb_mem_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [1:0]   req_i;
    logic [1:0]   we_i;
    logic [127:0] addr_i;
    logic [15:0]  be_i;
    logic [127:0] wdata_i;
    logic [1:0]   gnt_o;
    logic [1:0]   rvalid_o;
    logic [63:0]  rdata_o;
    logic         err_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [24:0]  mem_addr_o;
    logic [7:0]   mem_be_o;
    logic [63:0]  mem_wdata_o;
    logic [63:0]  mem_rdata_i;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] W5 = 64'hDEAD_BEEF_0000_0005;
    localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] OOR = 64'h0000_0000_1000_0000; // NumWords*8

    tb_mem_arbiter dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_be_o   (mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Small SRAM model (low 6 word-address bits), one-cycle read latency.
    logic [63:0] sram [64];
    initial begin
        for (int i = 0; i < 64; i++) sram[i] = 64'h0;
        sram[0]     = W0;
        sram[5]     = W5;
        sram[7]     = 64'h0;
        mem_rdata_i = 64'h0;
        forever begin
            @(posedge clk_i);
            if (mem_req_o) begin
                if (mem_we_o) begin
                    for (int b = 0; b < 8; b++)
                        if (mem_be_o[b]) sram[mem_addr_o[5:0]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
                end else begin
                    mem_rdata_i <= sram[mem_addr_o[5:0]];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic rq, input logic we, input logic [63:0] addr,
                            input logic [7:0] be, input logic [63:0] wd);
        req_i[p]           = rq;
        we_i[p]            = we;
        addr_i[p*64 +: 64] = addr;
        be_i[p*8 +: 8]     = be;
        wdata_i[p*64 +: 64] = wd;
    endtask

    task automatic idle();
        set_port(0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
        set_port(1, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();

        // Reset values, and grant stays combinational during reset.
        #2;
        chk("rst_rvalid", rvalid_o, 2'b00);
        chk("rst_err", err_o, 1'b0);
        chk("rst_rdata", rdata_o, 64'h0);
        chk("rst_memreq_idle", mem_req_o, 1'b0);
        set_port(1, 1'b1, 1'b0, 64'd0, 8'hFF, 64'h0);
        #1;
        chk("rst_gnt_comb", gnt_o, 2'b10);
        idle();
        @(negedge clk_i);
        rst_i = 1'b0;

        // Port 0 reads word 5.
        set_port(0, 1'b1, 1'b0, 64'd40, 8'hFF, 64'h0);
        #1;
        chk("rd5_gnt", gnt_o, 2'b01);
        chk("rd5_memreq", mem_req_o, 1'b1);
        chk("rd5_memwe", mem_we_o, 1'b0);
        chk("rd5_addr", mem_addr_o, 25'd5);
        @(posedge clk_i); #1;
        chk("rd5_rvalid", rvalid_o, 2'b01);
        chk("rd5_rdata", rdata_o, W5);
        chk("rd5_err", err_o, 1'b0);
        @(negedge clk_i);
        idle();
        @(posedge clk_i); #1;
        chk("idle_rvalid", rvalid_o, 2'b00);

        // Both ports request continuously from reset: strict alternation.
        idle();
        do_reset();
        set_port(0, 1'b1, 1'b0, 64'd40, 8'hFF, 64'h0);
        set_port(1, 1'b1, 1'b0, 64'd0,  8'hFF, 64'h0);
        for (int i = 0; i < 6; i++) begin
            logic [1:0] eg;
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk($sformatf("rr_gnt%0d", i), gnt_o, eg);
            @(posedge clk_i); #1;
            chk($sformatf("rr_rvalid%0d", i), rvalid_o, eg);
            chk($sformatf("rr_rdata%0d", i), rdata_o, (i % 2 == 0) ? W5 : W0);
            @(negedge clk_i);
        end
        idle();

        // Port 1 (again, as sole requester) writes low bytes of word 7.
        set_port(1, 1'b1, 1'b1, 64'd56, 8'h0F, 64'h1122_3344_5566_7788);
        #1;
        chk("wr7_gnt", gnt_o, 2'b10);
        chk("wr7_memwe", mem_we_o, 1'b1);
        chk("wr7_addr", mem_addr_o, 25'd7);
        chk("wr7_be", mem_be_o, 8'h0F);
        chk("wr7_wdata", mem_wdata_o, 64'h1122_3344_5566_7788);
        @(posedge clk_i); #1;
        chk("wr7_rvalid", rvalid_o, 2'b10);
        chk("wr7_rdata", rdata_o, 64'h0);
        @(negedge clk_i);
        idle();
        set_port(0, 1'b1, 1'b0, 64'd56, 8'hFF, 64'h0);
        #1;
        chk("rd7_gnt", gnt_o, 2'b01);
        @(posedge clk_i); #1;
        chk("rd7_rvalid", rvalid_o, 2'b01);
        chk("rd7_rdata", rdata_o, 64'h0000_0000_5566_7788);

        // Out-of-range read by port 0.
        @(negedge clk_i);
        set_port(0, 1'b1, 1'b0, OOR, 8'hFF, 64'h0);
        #1;
        chk("oor_gnt", gnt_o, 2'b01);
        chk("oor_memreq", mem_req_o, 1'b0);
        @(posedge clk_i); #1;
        chk("oor_rvalid", rvalid_o, 2'b01);
        chk("oor_err", err_o, 1'b1);
        chk("oor_rdata", rdata_o, 64'h0);

        // Out-of-range write that would alias word 5 must be dropped.
        @(negedge clk_i);
        set_port(0, 1'b1, 1'b1, OOR + 64'd40, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        chk("oorw_memreq", mem_req_o, 1'b0);
        @(posedge clk_i); #1;
        chk("oorw_err", err_o, 1'b1);
        @(negedge clk_i);
        set_port(0, 1'b1, 1'b0, 64'd40, 8'hFF, 64'h0);
        @(posedge clk_i); #1;
        chk("after_oorw_rd5", rdata_o, W5);
        chk("after_oorw_err", err_o, 1'b0);
        @(negedge clk_i);
        set_port(0, 1'b1, 1'b0, 64'd0, 8'hFF, 64'h0);
        #1;
        chk("rd0_addr", mem_addr_o, 25'd0);
        @(posedge clk_i); #1;
        chk("rd0_rdata", rdata_o, W0);
        chk("rd0_err", err_o, 1'b0);

        // Port 1 granted, then reset pulsed during the response cycle.
        @(negedge clk_i);
        idle();
        set_port(1, 1'b1, 1'b0, 64'd0, 8'hFF, 64'h0);
        #1;
        chk("rstmid_gnt", gnt_o, 2'b10);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        chk("rstmid_rvalid", rvalid_o, 2'b00);
        chk("rstmid_err", err_o, 1'b0);
        chk("rstmid_rdata", rdata_o, 64'h0);
        idle();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        set_port(0, 1'b1, 1'b0, 64'd40, 8'hFF, 64'h0);
        set_port(1, 1'b1, 1'b0, 64'd0,  8'hFF, 64'h0);
        #1;
        chk("postrst_gnt0", gnt_o, 2'b01);
        @(posedge clk_i); #1;
        chk("postrst_rvalid", rvalid_o, 2'b01);
        @(negedge clk_i);
        #1;
        chk("postrst_gnt1", gnt_o, 2'b10);
        idle();
        @(posedge clk_i); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tb_mem_arbiter.md
# tb_mem_arbiter

Round-robin arbiter that shares the test harness's single-port SRAM model between `NumPorts` word-level requesters, e.g. the AXI-to-memory bridge and a DMI/backdoor preload port. Every cycle it grants at most one request and drives the SRAM port with it. It routes the one-cycle-latency read data back to the granted requester and flags accesses beyond the SRAM as errors without touching the memory.

## Interface
- `NumPorts`, 2: number of requesters (≥2).
- `AddrWidth`, 64: requester byte-address width.
- `DataWidth`, 64: data width (multiple of 8).
- `NumWords`, 2**25: SRAM depth in words (power of two).
- Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  NumPorts  per-port request.
- `we_i`  in  NumPorts  per-port write enable.
- `addr_i`  in  NumPorts*AddrWidth  per-port byte address; port p occupies slice [p*AddrWidth +: AddrWidth].
- `be_i`  in  NumPorts*DataWidth/8  per-port byte enables.
- `wdata_i`  in  NumPorts*DataWidth  per-port write data.
- `gnt_o`  out  NumPorts  one-hot grant, same cycle as the accepted request.
- `rvalid_o`  out  NumPorts  one-hot response valid, one cycle after grant. Issued for reads and writes.
- `rdata_o`  out  DataWidth  response data, shared by all ports and qualified by `rvalid_o`.
- `err_o`  out  1  out-of-range flag, qualified by `rvalid_o`.
- `mem_req_o`  out  1  SRAM request.
- `mem_we_o`  out  1  SRAM write enable.
- `mem_addr_o`  out  $clog2(NumWords)  SRAM word index.
- `mem_be_o`  out  DataWidth/8  SRAM byte enables.
- `mem_wdata_o`  out  DataWidth  SRAM write data.
- `mem_rdata_i`  in  DataWidth  SRAM read data, valid one cycle after `mem_req_o`.

## Operation
- Word index = `addr_i[p] >> $clog2(DataWidth/8)`.
- An access is in range iff word index < NumWords, i.e. all byte-address bits above `$clog2(NumWords)+$clog2(DataWidth/8)-1` are zero. Low byte-offset bits are ignored.
- Arbitration is combinational round-robin.
  - Register `last_q` holds the index of the last granted port.
  - Priority starts at `(last_q+1) mod NumPorts`.
  - The first requesting port in that order wins.
  - `last_q` updates to the winner only on a cycle with a grant; otherwise it holds.
- Granted and in range:
  - `mem_req_o`=1.
  - `mem_we_o`, `mem_addr_o`, `mem_be_o` and `mem_wdata_o` are taken from the winner.
- Granted and out of range:
  - `mem_req_o`=0, so the SRAM is not accessed; writes are dropped.
  - The slot is still consumed.
- When nothing is granted, `mem_req_o`=0 and all other `mem_*` outputs are 0.
- Response register, loaded every cycle:
  - `rsp_port_q` = one-hot grant.
  - `rsp_err_q` = winner out of range.
  - `rsp_we_q` = winner we.
- Next-cycle response outputs:
  - `rvalid_o` = `rsp_port_q`.
  - `err_o` = `rsp_err_q` while `rvalid_o` is nonzero, else 0.
  - `rdata_o` = `mem_rdata_i` for an in-range read, else 0 (writes and errors).
- Requesters hold their request until granted. A port whose request drops before grant loses nothing and receives no response.

## Timing
- Grant and SRAM request occur in cycle N, combinationally from `req_i`. The response arrives in cycle N+1. One access per cycle, full throughput: back-to-back grants are allowed, including repeated grants to the same port when it is the only requester.
- Reset values:
  - `last_q` = NumPorts-1, so port 0 has first priority.
  - `rsp_port_q` = 0, so `rvalid_o`=0 and `err_o`=0.
  - `rdata_o`=0 during reset.
  - `gnt_o` and `mem_*` still follow the combinational inputs.
- Reset asserted mid-operation: the pending response is discarded (`rvalid_o` drops asynchronously) and priority returns to port 0.
- Simultaneous requests from all ports: each port is granted within NumPorts cycles (starvation-free).
- Wrap-around: with `last_q`=NumPorts-1, priority scans from port 0.

## Test plan
- Reset, then port 0 reads word 5 preloaded with 0xDEAD_BEEF_0000_0005:
  - `gnt_o`=01 and `mem_addr_o`=5 in cycle N.
  - `rvalid_o`=01, `rdata_o`=0xDEAD_BEEF_0000_0005, `err_o`=0 in N+1.
- Both ports request continuously for 6 cycles from reset: grants alternate 01,10,01,10,01,10, and each `rvalid_o` matches the previous cycle's grant.
- Port 1 writes 0x1122334455667788 with be=0x0F to word 7 holding 0, then port 0 reads word 7:
  - write response has `rvalid_o`=10 and `rdata_o`=0.
  - read returns 0x0000000055667788.
- Port 0 accesses byte address NumWords*8:
  - `mem_req_o`=0 and `gnt_o`=01.
  - next cycle `rvalid_o`=01, `err_o`=1, `rdata_o`=0.
  - a subsequent read of word 0 is unaffected.
- Port 1 granted in cycle N, then `rst_i` is pulsed during N+1:
  - `rvalid_o` is 0 while reset is asserted.
  - after release, with both ports requesting, port 0 is granted first.
